// File: rtl/video_pkg.sv
// video_pkg: 720p raster timing defaults and the signed coordinate type
// shared by the timing, sprite and paddle blocks.
package video_pkg;
  localparam int HRES = 1280;
  localparam int HFP = 110;
  localparam int HSW = 40;
  localparam int HBP = 220;
  localparam int VRES = 720;
  localparam int VFP = 5;
  localparam int VSW = 5;
  localparam int VBP = 20;
  localparam int HTOTAL = HRES + HFP + HSW + HBP;
  localparam int VTOTAL = VRES + VFP + VSW + VBP;
  typedef logic signed [11:0] coord_t;
endpackage

// File: rtl/sync_delay.sv
// sync_delay: W-bit wide, D-deep shift register with per-bit asynchronous
// reset values; D=0 is a plain wire.
module sync_delay #(
  parameter int W = 1,
  parameter int D = 1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);
  if (D == 0) begin : g_pass
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst;
    assign dout = din;
  end else begin : g_sr
    logic [D-1:0][W-1:0] sr_d, sr_q;
    always_comb begin
      sr_d[0] = din;
      for (int i = 1; i < D; i++) sr_d[i] = sr_q[i-1];
    end
    always_ff @(posedge clk or posedge rst)
      if (rst) sr_q <= {D{RST_VAL}};
      else sr_q <= sr_d;
    assign dout = sr_q[D-1];
  end
endmodule

// File: rtl/video_timing_gen.sv
// video_timing_gen: free-running raster counters, frame pulse and
// delay-aligned hsync/vsync/de for the display path.
module video_timing_gen
  import video_pkg::*;
#(
  parameter int HRES = video_pkg::HRES,
  parameter int HFP = video_pkg::HFP,
  parameter int HSW = video_pkg::HSW,
  parameter int HBP = video_pkg::HBP,
  parameter int VRES = video_pkg::VRES,
  parameter int VFP = video_pkg::VFP,
  parameter int VSW = video_pkg::VSW,
  parameter int VBP = video_pkg::VBP,
  parameter bit HS_POL = 1'b1,
  parameter bit VS_POL = 1'b1,
  parameter int SYNC_DLY = 1
) (
  input  logic   pixel_clk,
  input  logic   rst,
  output coord_t hpos,
  output coord_t vpos,
  output logic   fsync,
  output logic   hsync,
  output logic   vsync,
  output logic   de
);
  localparam int H_TOT = HRES + HFP + HSW + HBP;
  localparam int V_TOT = VRES + VFP + VSW + VBP;
  if (H_TOT > 2047 || V_TOT > 2047) begin : g_bad_total
    $error("video_timing_gen: HTOTAL/VTOTAL must not exceed 2047");
  end
  if (SYNC_DLY < 0 || SYNC_DLY > 7) begin : g_bad_dly
    $error("video_timing_gen: SYNC_DLY must be 0..7");
  end
  localparam coord_t H_LAST = coord_t'(H_TOT - 1);
  localparam coord_t V_LAST = coord_t'(V_TOT - 1);
  localparam coord_t H_ACT = coord_t'(HRES);
  localparam coord_t V_ACT = coord_t'(VRES);
  localparam coord_t HS_ON = coord_t'(HRES + HFP);
  localparam coord_t HS_OFF = coord_t'(HRES + HFP + HSW);
  localparam coord_t VS_ON = coord_t'(VRES + VFP);
  localparam coord_t VS_OFF = coord_t'(VRES + VFP + VSW);
  coord_t hpos_d, hpos_q, vpos_d, vpos_q;
  logic fsync_d, fsync_q, hs_raw, vs_raw, de_raw;
  logic [2:0] sync_dly;
  always_comb begin
    hpos_d = (hpos_q == H_LAST) ? '0 : hpos_q + coord_t'(1);
    vpos_d = (hpos_q != H_LAST) ? vpos_q : (vpos_q == V_LAST) ? '0 : vpos_q + coord_t'(1);
    // fsync is registered from the next position so it coincides with (0,VRES)
    fsync_d = (hpos_d == '0) && (vpos_d == V_ACT);
    de_raw = (hpos_q < H_ACT) && (vpos_q < V_ACT);
    hs_raw = (hpos_q >= HS_ON) && (hpos_q < HS_OFF);
    vs_raw = (vpos_q >= VS_ON) && (vpos_q < VS_OFF);
  end
  always_ff @(posedge pixel_clk or posedge rst)
    if (rst) begin
      hpos_q <= '0;
      vpos_q <= '0;
      fsync_q <= 1'b0;
    end else begin
      hpos_q <= hpos_d;
      vpos_q <= vpos_d;
      fsync_q <= fsync_d;
    end
  sync_delay #(.W(3), .D(SYNC_DLY), .RST_VAL(3'b000)) u_sync_delay (
    .clk(pixel_clk),
    .rst(rst),
    .din({hs_raw, vs_raw, de_raw}),
    .dout(sync_dly)
  );
  assign hpos = hpos_q;
  assign vpos = vpos_q;
  assign fsync = fsync_q;
  assign hsync = HS_POL ? sync_dly[2] : ~sync_dly[2];
  assign vsync = VS_POL ? sync_dly[1] : ~sync_dly[1];
  assign de = sync_dly[0];
endmodule
